// File: rtl/pll_config_sequencer.sv
// PLL loop-filter configuration sequencer: holds the loop in reset, applies kp/ki/n, qualifies lock.
// Build macro PLL_SEQ_AUTO_RELOCK_EN enables bounded automatic re-lock attempts on timeout or lock loss.
module pll_config_sequencer #(
    parameter int KP_W         = 16,
    parameter int KI_W         = 16,
    parameter int N_W          = 8,
    parameter int HOLD_CYCLES  = 16,
    parameter int LOCK_STABLE  = 8,
    parameter int LOCK_TIMEOUT = 4096,
    parameter int RETRY_MAX    = 3
) (
    input  logic            HCLK,
    input  logic            HRESET,
    input  logic [KP_W-1:0] kp_reg,
    input  logic [KI_W-1:0] ki_reg,
    input  logic [N_W-1:0]  n_reg,
    input  logic            pll_enable,
    input  logic            pll_lock,
    output logic [KP_W-1:0] pll_kp,
    output logic [KI_W-1:0] pll_ki,
    output logic [N_W-1:0]  pll_n,
    output logic            pll_rst,
    output logic            pll_en,
    output logic            locked,
    output logic            busy,
    output logic            fault,
    output logic            timeout_flag,
    output logic            lock_lost,
    output logic [2:0]      dbg_state
);

    localparam int CNT_W = $clog2(LOCK_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(LOCK_STABLE - 1);
    localparam logic [CNT_W-1:0] TIMER_LAST  = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX     = '1;

    typedef enum logic [2:0] {
        ST_OFF       = 3'd0,
        ST_HOLD      = 3'd1,
        ST_LOAD      = 3'd2,
        ST_WAIT_LOCK = 3'd3,
        ST_LOCKED    = 3'd4,
        ST_FAULT     = 3'd5
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic             r_lock_meta;
    logic             r_lock_s;
    logic [KP_W-1:0]  r_kp_sh;
    logic [KI_W-1:0]  r_ki_sh;
    logic [N_W-1:0]   r_n_sh;
    logic [CNT_W-1:0] r_timer;
    logic [CNT_W-1:0] w_timer_nxt;
    logic [CNT_W-1:0] r_stable;
    logic [CNT_W-1:0] w_stable_nxt;
    logic [KP_W-1:0]  r_pll_kp;
    logic [KI_W-1:0]  r_pll_ki;
    logic [N_W-1:0]   r_pll_n;
    logic             r_pll_rst;
    logic             r_pll_en;
    logic             r_locked;
    logic             r_busy;
    logic             r_fault;
    logic             r_timeout_flag;
    logic             r_lock_lost;
    logic             w_param_change;
    logic             w_capture;
    logic             w_apply;
    logic             w_set_timeout;
    logic             w_set_lost;
    logic             w_clear_sticky;
    logic             w_fail;

`ifdef PLL_SEQ_AUTO_RELOCK_EN
    localparam int RTY_W = (RETRY_MAX < 1) ? 1 : $clog2(RETRY_MAX + 1);
    localparam logic [RTY_W-1:0] RTY_LIMIT = RTY_W'(RETRY_MAX);
    logic [RTY_W-1:0] r_retry_cnt;
    logic             w_retry_inc;
`endif

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + 1'b1;
    endfunction

    assign w_param_change = ({kp_reg, ki_reg, n_reg} != {r_kp_sh, r_ki_sh, r_n_sh});

    // Priority: disable beats param change, which beats lock/timer events.
    always_comb begin
        w_state_nxt    = r_state;
        w_timer_nxt    = r_timer;
        w_stable_nxt   = r_stable;
        w_capture      = 1'b0;
        w_apply        = 1'b0;
        w_set_timeout  = 1'b0;
        w_set_lost     = 1'b0;
        w_clear_sticky = 1'b0;
        w_fail         = 1'b0;
`ifdef PLL_SEQ_AUTO_RELOCK_EN
        w_retry_inc    = 1'b0;
`endif
        if (r_state != ST_OFF && !pll_enable) begin
            w_state_nxt  = ST_OFF;
            w_timer_nxt  = '0;
            w_stable_nxt = '0;
        end else if (r_state inside {ST_HOLD, ST_LOAD, ST_WAIT_LOCK, ST_LOCKED} && w_param_change) begin
            w_state_nxt  = ST_HOLD;
            w_capture    = 1'b1;
            w_timer_nxt  = '0;
            w_stable_nxt = '0;
        end else begin
            case (r_state)
                ST_OFF: begin
                    if (pll_enable) begin
                        w_state_nxt    = ST_HOLD;
                        w_capture      = 1'b1;
                        w_clear_sticky = 1'b1;
                        w_timer_nxt    = '0;
                        w_stable_nxt   = '0;
                    end
                end
                ST_HOLD: begin
                    if (r_timer >= HOLD_LAST) begin
                        w_state_nxt = ST_LOAD;
                        w_timer_nxt = '0;
                    end else begin
                        w_timer_nxt = sat_inc(r_timer);
                    end
                end
                ST_LOAD: begin
                    w_apply      = 1'b1;
                    w_state_nxt  = ST_WAIT_LOCK;
                    w_timer_nxt  = '0;
                    w_stable_nxt = '0;
                end
                ST_WAIT_LOCK: begin
                    // A qualifying lock sample wins over a simultaneous timeout.
                    if (r_lock_s && r_stable >= STABLE_LAST) begin
                        w_state_nxt  = ST_LOCKED;
                        w_timer_nxt  = '0;
                        w_stable_nxt = '0;
                    end else if (r_timer >= TIMER_LAST) begin
                        w_set_timeout = 1'b1;
                        w_fail        = 1'b1;
                    end else begin
                        w_timer_nxt  = sat_inc(r_timer);
                        w_stable_nxt = r_lock_s ? sat_inc(r_stable) : '0;
                    end
                end
                ST_LOCKED: begin
                    if (!r_lock_s) begin
                        w_set_lost = 1'b1;
                        w_fail     = 1'b1;
                    end
                end
                ST_FAULT: begin
                    w_state_nxt = ST_FAULT;
                end
                default: begin
                    w_state_nxt = ST_OFF;
                end
            endcase
        end

        if (w_fail) begin
            w_timer_nxt  = '0;
            w_stable_nxt = '0;
`ifdef PLL_SEQ_AUTO_RELOCK_EN
            if (r_retry_cnt < RTY_LIMIT) begin
                w_state_nxt = ST_HOLD;
                w_retry_inc = 1'b1;
            end else begin
                w_state_nxt = ST_FAULT;
            end
`else
            w_state_nxt = ST_FAULT;
`endif
        end
    end

    // Outputs decode the current state, so they follow state entry by one cycle.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            r_state        <= ST_OFF;
            r_lock_meta    <= 1'b0;
            r_lock_s       <= 1'b0;
            r_kp_sh        <= '0;
            r_ki_sh        <= '0;
            r_n_sh         <= '0;
            r_timer        <= '0;
            r_stable       <= '0;
            r_pll_kp       <= '0;
            r_pll_ki       <= '0;
            r_pll_n        <= '0;
            r_pll_rst      <= 1'b1;
            r_pll_en       <= 1'b0;
            r_locked       <= 1'b0;
            r_busy         <= 1'b0;
            r_fault        <= 1'b0;
            r_timeout_flag <= 1'b0;
            r_lock_lost    <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_lock_meta <= pll_lock;
            r_lock_s    <= r_lock_meta;
            r_timer     <= w_timer_nxt;
            r_stable    <= w_stable_nxt;
            if (w_capture) begin
                r_kp_sh <= kp_reg;
                r_ki_sh <= ki_reg;
                r_n_sh  <= n_reg;
            end
            if (w_apply) begin
                r_pll_kp <= r_kp_sh;
                r_pll_ki <= r_ki_sh;
                r_pll_n  <= r_n_sh;
            end
            if (w_clear_sticky) begin
                r_timeout_flag <= 1'b0;
                r_lock_lost    <= 1'b0;
            end else begin
                if (w_set_timeout) r_timeout_flag <= 1'b1;
                if (w_set_lost)    r_lock_lost    <= 1'b1;
            end
            r_pll_rst <= !(r_state == ST_WAIT_LOCK || r_state == ST_LOCKED);
            r_pll_en  <= (r_state == ST_WAIT_LOCK || r_state == ST_LOCKED);
            r_locked  <= (r_state == ST_LOCKED);
            r_busy    <= (r_state == ST_HOLD || r_state == ST_LOAD || r_state == ST_WAIT_LOCK);
            r_fault   <= (r_state == ST_FAULT);
        end
    end

`ifdef PLL_SEQ_AUTO_RELOCK_EN
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            r_retry_cnt <= '0;
        end else if (w_state_nxt == ST_OFF || (w_state_nxt == ST_LOCKED && r_state != ST_LOCKED)) begin
            r_retry_cnt <= '0;
        end else if (w_retry_inc) begin
            r_retry_cnt <= r_retry_cnt + 1'b1;
        end
    end
`endif

    assign pll_kp       = r_pll_kp;
    assign pll_ki       = r_pll_ki;
    assign pll_n        = r_pll_n;
    assign pll_rst      = r_pll_rst;
    assign pll_en       = r_pll_en;
    assign locked       = r_locked;
    assign busy         = r_busy;
    assign fault        = r_fault;
    assign timeout_flag = r_timeout_flag;
    assign lock_lost    = r_lock_lost;
    assign dbg_state    = r_state;

endmodule
